// File: rtl/dcache_pkg.sv
// Shared FSM encoding and geometry helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic int offset_bits(input int line_length);
        return $clog2(line_length);
    endfunction

    function automatic int index_bits(input int nlines);
        return $clog2(nlines);
    endfunction

    function automatic int tag_bits(input int pa, input int line_length, input int nlines);
        return pa - $clog2(line_length) - $clog2(nlines);
    endfunction

    function automatic int line_beats(input int line_length, input int mw);
        return (line_length * 8) / mw;
    endfunction

    function automatic int cnt_bits(input int line_length, input int mw);
        return (line_beats(line_length, mw) > 1) ? $clog2(line_beats(line_length, mw)) : 1;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: per-set tag/valid/dirty state, line storage with beat and
// lane/byte write ports, and a combinational tag compare for the addressed set.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int NLINES      = 4,
    parameter int RV          = 16,
    parameter int PA          = 22,
    parameter int MW          = 4
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [index_bits(NLINES)-1:0]               index,
    input  logic [tag_bits(PA, LINE_LENGTH, NLINES)-1:0] ptag,
    output logic                                        hit,
    output logic                                        valid,
    output logic                                        dirty,
    output logic [tag_bits(PA, LINE_LENGTH, NLINES)-1:0] tag,
    output logic [LINE_LENGTH*8-1:0]                    line,
    input  logic                                        beat_we,
    input  logic [cnt_bits(LINE_LENGTH, MW)-1:0]        beat_sel,
    input  logic [MW-1:0]                               beat_data,
    input  logic                                        lane_we,
    input  logic                                        is_byte,
    input  logic [offset_bits(LINE_LENGTH)-1:0]         offset,
    input  logic [RV-1:0]                               wdata,
    input  logic                                        install,
    input  logic                                        clr_dirty
);
    localparam int TB         = tag_bits(PA, LINE_LENGTH, NLINES);
    localparam int LB         = LINE_LENGTH * 8;
    localparam int LANE_BYTES = RV / 8;

    logic [TB-1:0]     tag_mem  [NLINES];
    logic [LB-1:0]     data_mem [NLINES];
    logic [NLINES-1:0] valid_mem;
    logic [NLINES-1:0] dirty_mem;
    logic [LB-1:0]     merged;

    assign tag   = tag_mem[index];
    assign valid = valid_mem[index];
    assign dirty = dirty_mem[index];
    assign line  = data_mem[index];
    assign hit   = valid_mem[index] && (tag_mem[index] == ptag);

    // Store merge: a byte store touches one byte, a word store the whole aligned lane.
    always_comb begin
        merged = data_mem[index];
        for (int b = 0; b < LINE_LENGTH; b++) begin
            if (is_byte ? (b == int'(offset))
                        : ((b / LANE_BYTES) == (int'(offset) / LANE_BYTES))) begin
                merged[b*8 +: 8] = is_byte ? wdata[7:0] : wdata[(b % LANE_BYTES)*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_mem <= '0;
            dirty_mem <= '0;
        end else if (install) begin
            valid_mem[index] <= 1'b1;
            dirty_mem[index] <= 1'b0;
        end else if (clr_dirty) begin
            dirty_mem[index] <= 1'b0;
        end else if (lane_we) begin
            dirty_mem[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[index] <= ptag;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_mem[index][int'(beat_sel)*MW +: MW] <= beat_data;
        end else if (lane_we) begin
            data_mem[index] <= merged;
        end
    end

endmodule

// File: rtl/dcache_sa.sv
// Set-associative write-back, write-allocate data cache with LRU replacement and
// an internal writeback/fill sequencer driving a narrow memory beat port.
module dcache_sa
    import dcache_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int NLINES      = 4,
    parameter int WAYS        = 2,
    parameter int RV          = 16,
    parameter int PA          = 22,
    parameter int MW          = 4
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    req,
    input  logic                                    write,
    input  logic                                    is_byte,
    input  logic                                    fault,
    input  logic [PA-1:0]                           paddr,
    input  logic [RV-1:0]                           wdata,
    output logic                                    ready,
    output logic [RV-1:0]                           rdata,
    output logic                                    mreq,
    output logic                                    mwrite,
    output logic [PA-offset_bits(LINE_LENGTH)-1:0]  maddr,
    output logic [MW-1:0]                           mwdata,
    input  logic [MW-1:0]                           mrdata,
    input  logic                                    mstrobe
);
    localparam int OB         = offset_bits(LINE_LENGTH);
    localparam int IB         = index_bits(NLINES);
    localparam int TB         = tag_bits(PA, LINE_LENGTH, NLINES);
    localparam int BEATS      = line_beats(LINE_LENGTH, MW);
    localparam int CB         = cnt_bits(LINE_LENGTH, MW);
    localparam int LB         = LINE_LENGTH * 8;
    localparam int LANE_BYTES = RV / 8;

    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TB-1:0] ptag;

    assign offset = paddr[OB-1:0];
    assign index  = paddr[OB +: IB];
    assign ptag   = paddr[PA-1 -: TB];

    state_t        state;
    state_t        state_next;
    logic [CB-1:0] cnt;
    logic          victim;
    logic          victim_next;
    logic          victim_pick;

    logic [WAYS-1:0] way_hit;
    logic [WAYS-1:0] way_valid;
    logic [WAYS-1:0] way_dirty;
    logic [WAYS-1:0] sel;
    logic [TB-1:0]   way_tag  [WAYS];
    logic [LB-1:0]   way_line [WAYS];

    logic          lookup;
    logic          hit_any;
    logic          hit_way;
    logic          lru_way;
    logic          last;
    logic          fill_fire;
    logic          wb_fire;
    logic [LB-1:0] hit_line;
    logic [LB-1:0] victim_line;
    logic [TB-1:0] victim_tag;

    assign lookup    = reset_n && req && !fault && (state == IDLE);
    assign hit_any   = lookup && (|way_hit);
    assign last      = (cnt == CB'(BEATS - 1));
    assign fill_fire = (state == FILL) && mstrobe;
    assign wb_fire   = (state == WB) && mstrobe;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign sel[w] = (int'(victim) == w);

        dcache_way #(
            .LINE_LENGTH (LINE_LENGTH),
            .NLINES      (NLINES),
            .RV          (RV),
            .PA          (PA),
            .MW          (MW)
        ) u_way (
            .clk       (clk),
            .reset_n   (reset_n),
            .index     (index),
            .ptag      (ptag),
            .hit       (way_hit[w]),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .line      (way_line[w]),
            .beat_we   (fill_fire && sel[w]),
            .beat_sel  (cnt),
            .beat_data (mrdata),
            .lane_we   (lookup && write && way_hit[w]),
            .is_byte   (is_byte),
            .offset    (offset),
            .wdata     (wdata),
            .install   (fill_fire && last && sel[w]),
            .clr_dirty (wb_fire && last && sel[w])
        );
    end

    // lru[set] names the way to replace next; a hit points it at the other way.
    if (WAYS > 1) begin : g_lru
        logic [NLINES-1:0] lru;

        assign hit_way = way_hit[WAYS-1];
        assign lru_way = lru[index];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                lru <= '0;
            end else if (hit_any) begin
                lru[index] <= ~hit_way;
            end
        end
    end else begin : g_no_lru
        assign hit_way = 1'b0;
        assign lru_way = 1'b0;
    end

    always_comb begin
        victim_pick = lru_way;
        if (!way_valid[0]) begin
            victim_pick = 1'b0;
        end else if ((WAYS > 1) && !way_valid[WAYS-1]) begin
            victim_pick = 1'b1;
        end
    end

    assign hit_line    = way_line[hit_way];
    assign victim_line = way_line[victim];
    assign victim_tag  = way_tag[victim];

    assign ready = reset_n && req && (fault || ((state == IDLE) && (|way_hit)));

    always_comb begin
        rdata = '0;
        if (hit_any) begin
            if (is_byte) begin
                rdata = RV'(hit_line[int'(offset)*8 +: 8]);
            end else begin
                rdata = hit_line[(int'(offset) / LANE_BYTES)*RV +: RV];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            victim <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
            if ((state != IDLE) && mstrobe) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        victim_next = victim;
        mreq        = 1'b0;
        mwrite      = 1'b0;
        maddr       = {ptag, index};
        mwdata      = '0;
        case (state)
            IDLE: begin
                if (lookup && !(|way_hit)) begin
                    victim_next = victim_pick;
                    state_next  = (way_valid[victim_pick] && way_dirty[victim_pick]) ? WB : FILL;
                end
            end
            WB: begin
                mreq   = 1'b1;
                mwrite = 1'b1;
                maddr  = {victim_tag, index};
                mwdata = victim_line[int'(cnt)*MW +: MW];
                if (mstrobe && last) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mreq = 1'b1;
                if (mstrobe && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_sa.sv
// Bench for dcache_sa: directed scenarios plus randomized traffic checked against a
// behavioural cache/memory model held in plain arrays.
module tb_dcache_sa;
    localparam int LINE_LENGTH = 4;
    localparam int NLINES      = 4;
    localparam int WAYS        = 2;
    localparam int RV          = 16;
    localparam int PA          = 22;
    localparam int MW          = 4;
    localparam int BEATS       = 8;
    localparam int MA          = 20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req;
    logic          write;
    logic          is_byte;
    logic          fault;
    logic [PA-1:0] paddr;
    logic [RV-1:0] wdata;
    logic          ready;
    logic [RV-1:0] rdata;
    logic          mreq;
    logic          mwrite;
    logic [MA-1:0] maddr;
    logic [MW-1:0] mwdata;
    logic [MW-1:0] mrdata;
    logic          mstrobe;

    dcache_sa #(
        .LINE_LENGTH (LINE_LENGTH),
        .NLINES      (NLINES),
        .WAYS        (WAYS),
        .RV          (RV),
        .PA          (PA),
        .MW          (MW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .write   (write),
        .is_byte (is_byte),
        .fault   (fault),
        .paddr   (paddr),
        .wdata   (wdata),
        .ready   (ready),
        .rdata   (rdata),
        .mreq    (mreq),
        .mwrite  (mwrite),
        .maddr   (maddr),
        .mwdata  (mwdata),
        .mrdata  (mrdata),
        .mstrobe (mstrobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Held-request protocol: once req is pending, req and paddr must not move.
    logic          pend_q = 1'b0;
    logic [PA-1:0] paddr_q = '0;
    always @(posedge clk) begin
        if (reset_n && pend_q) begin
            assert (req && (paddr == paddr_q))
                else $error("illegal request change while waiting for ready");
        end
        pend_q  <= reset_n && req && !ready;
        paddr_q <= paddr;
    end

    logic [31:0] mem     [int];
    logic [31:0] ref_mem [int];

    bit          mv   [NLINES][WAYS];
    bit          md   [NLINES][WAYS];
    logic [17:0] mt   [NLINES][WAYS];
    logic [31:0] mdat [NLINES][WAYS];
    int          mru  [NLINES];

    bit          e_hit;
    logic [15:0] e_rdata;
    bit          e_wb;
    logic [19:0] e_wb_addr;
    logic [31:0] e_wb_line;
    logic [19:0] e_fill_addr;

    bit          use_stall;
    bit          o_timeout;
    int          o_lat;
    logic [15:0] o_rdata;
    logic        o_mreq0;
    int          o_wb_n;
    int          o_fill_n;
    logic [19:0] o_wb_addr;
    logic [19:0] o_fill_addr;
    logic [31:0] o_wb_line;

    task automatic init_mem();
        for (int a = 0; a < 32; a++) mem[a] = $urandom;
        mem[4] = 32'h8765_4321;
        for (int a = 0; a < 32; a++) ref_mem[a] = mem[a];
    endtask

    task automatic model_reset();
        for (int s = 0; s < NLINES; s++) begin
            mru[s] = -1;
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
            end
        end
    endtask

    task automatic model_access(input bit w, input bit b, input bit f,
                                input logic [PA-1:0] a, input logic [15:0] d);
        int          set;
        int          way;
        int          off;
        logic [17:0] tg;
        logic [31:0] line;
        e_hit = 1; e_wb = 0; e_rdata = '0;
        e_wb_addr = '0; e_wb_line = '0; e_fill_addr = '0;
        if (f) return;
        set = int'(a[3:2]);
        tg  = a[21:4];
        off = int'(a[1:0]);
        way = -1;
        for (int i = 0; i < WAYS; i++) if (mv[set][i] && mt[set][i] == tg) way = i;
        if (way < 0) begin
            e_hit = 0;
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[set][i]) way = i;
            if (way < 0) way = (mru[set] == 0) ? 1 : 0;
            if (md[set][way]) begin
                e_wb      = 1;
                e_wb_addr = {mt[set][way], 2'(set)};
                e_wb_line = mdat[set][way];
                ref_mem[int'(e_wb_addr)] = mdat[set][way];
            end
            e_fill_addr    = {tg, 2'(set)};
            mdat[set][way] = ref_mem[int'(e_fill_addr)];
            mt[set][way]   = tg;
            mv[set][way]   = 1;
            md[set][way]   = 0;
        end
        line = mdat[set][way];
        if (b) e_rdata = {8'h00, line[off*8 +: 8]};
        else   e_rdata = line[(off/2)*16 +: 16];
        if (w) begin
            if (b) line[off*8 +: 8] = d[7:0];
            else   line[(off/2)*16 +: 16] = d;
            mdat[set][way] = line;
            md[set][way]   = 1;
        end
        mru[set] = way;
    endtask

    // Presents one access, acts as the memory for any bursts, and records what it saw.
    task automatic do_access(input bit w, input bit b, input bit f,
                             input logic [PA-1:0] a, input logic [15:0] d);
        int          beat;
        bit          done;
        bit          stb;
        logic [31:0] tmp;
        beat = 0; done = 0;
        o_timeout = 0; o_lat = -1; o_rdata = '0; o_mreq0 = 1'b0;
        o_wb_n = 0; o_fill_n = 0; o_wb_addr = '0; o_fill_addr = '0; o_wb_line = '0;
        @(negedge clk);
        req = 1; write = w; is_byte = b; fault = f; paddr = a; wdata = d;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (c == 0) o_mreq0 = mreq;
            if (ready) begin
                o_lat = c; o_rdata = rdata; done = 1;
                break;
            end
            if (mreq) begin
                stb = use_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                tmp = mem[int'(maddr)];
                mrdata  = tmp[beat*4 +: 4];
                mstrobe = stb;
                if (stb) begin
                    if (mwrite) begin
                        o_wb_line[beat*4 +: 4] = mwdata;
                        o_wb_addr = maddr;
                        o_wb_n++;
                    end else begin
                        o_fill_addr = maddr;
                        o_fill_n++;
                    end
                    beat = (beat == BEATS - 1) ? 0 : beat + 1;
                    if (mwrite && beat == 0) mem[int'(maddr)] = o_wb_line;
                end
            end
            @(posedge clk);
            @(negedge clk);
            mstrobe = 0;
        end
        if (done) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            o_timeout = 1;
        end
        req = 0; write = 0; is_byte = 0; fault = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; req = 1; paddr = 22'h000010;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b want 0", mreq); end
        checks++; if (mwrite !== 1'b0) begin errors++; $display("FAIL reset_mwrite got %b want 0", mwrite); end
        req = 0;
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_first_fill();
        do_access(0, 0, 0, 22'h000010, 16'h0);
        model_access(0, 0, 0, 22'h000010, 16'h0);
        checks++; if (o_timeout) begin errors++; $display("FAIL first_timeout got 1 want 0"); end
        checks++; if (o_lat != 9) begin errors++; $display("FAIL first_latency got %0d want 9", o_lat); end
        checks++; if (o_fill_n != 8 || o_wb_n != 0) begin errors++; $display("FAIL first_beats got fill %0d wb %0d want 8 0", o_fill_n, o_wb_n); end
        checks++; if (o_fill_addr !== 20'h00004) begin errors++; $display("FAIL first_maddr got %h want 00004", o_fill_addr); end
        checks++; if (o_rdata !== 16'h4321) begin errors++; $display("FAIL first_rdata got %h want 4321", o_rdata); end
    endtask

    task automatic test_hit_latency();
        do_access(0, 0, 0, 22'h000012, 16'h0);
        model_access(0, 0, 0, 22'h000012, 16'h0);
        checks++; if (o_lat != 0) begin errors++; $display("FAIL hit_latency got %0d want 0", o_lat); end
        checks++; if (o_rdata !== 16'h8765) begin errors++; $display("FAIL hit_rdata got %h want 8765", o_rdata); end
        checks++; if (o_mreq0 !== 1'b0) begin errors++; $display("FAIL hit_mreq got %b want 0", o_mreq0); end
    endtask

    task automatic test_byte_store();
        do_access(1, 1, 0, 22'h000011, 16'h00AB);
        model_access(1, 1, 0, 22'h000011, 16'h00AB);
        checks++; if (o_lat != 0) begin errors++; $display("FAIL bstore_latency got %0d want 0", o_lat); end
        do_access(0, 0, 0, 22'h000010, 16'h0);
        model_access(0, 0, 0, 22'h000010, 16'h0);
        checks++; if (o_rdata !== 16'hAB21) begin errors++; $display("FAIL bstore_rdata got %h want AB21", o_rdata); end
        do_access(0, 1, 0, 22'h000011, 16'h0);
        model_access(0, 1, 0, 22'h000011, 16'h0);
        checks++; if (o_rdata !== 16'h00AB) begin errors++; $display("FAIL byte_load got %h want 00AB", o_rdata); end
    endtask

    task automatic test_eviction();
        do_access(0, 0, 0, 22'h000020, 16'h0);
        model_access(0, 0, 0, 22'h000020, 16'h0);
        checks++; if (o_lat != 9 || o_wb_n != 0) begin errors++; $display("FAIL evict_second_fill got lat %0d wb %0d want 9 0", o_lat, o_wb_n); end
        checks++; if (o_fill_addr !== 20'h00008) begin errors++; $display("FAIL evict_second_maddr got %h want 00008", o_fill_addr); end
        do_access(0, 0, 0, 22'h000030, 16'h0);
        model_access(0, 0, 0, 22'h000030, 16'h0);
        checks++; if (o_lat != 17) begin errors++; $display("FAIL evict_latency got %0d want 17", o_lat); end
        checks++; if (o_wb_n != 8) begin errors++; $display("FAIL evict_wb_beats got %0d want 8", o_wb_n); end
        checks++; if (o_wb_addr !== 20'h00004) begin errors++; $display("FAIL evict_wb_maddr got %h want 00004", o_wb_addr); end
        checks++; if (o_wb_line !== 32'h8765AB21) begin errors++; $display("FAIL evict_wb_data got %h want 8765ab21", o_wb_line); end
        checks++; if (o_fill_addr !== 20'h0000C || o_fill_n != 8) begin errors++; $display("FAIL evict_fill got %h/%0d want 0000c/8", o_fill_addr, o_fill_n); end
        checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL evict_rdata got %h want %h", o_rdata, e_rdata); end
    endtask

    task automatic test_fault();
        do_access(1, 0, 1, 22'h000054, 16'h1234);
        model_access(1, 0, 1, 22'h000054, 16'h1234);
        checks++; if (o_lat != 0) begin errors++; $display("FAIL fault_latency got %0d want 0", o_lat); end
        checks++; if (o_mreq0 !== 1'b0 || o_fill_n + o_wb_n != 0) begin errors++; $display("FAIL fault_mem got mreq %b beats %0d want 0 0", o_mreq0, o_fill_n + o_wb_n); end
        do_access(0, 0, 1, 22'h000030, 16'h0);
        model_access(0, 0, 1, 22'h000030, 16'h0);
        checks++; if (o_rdata !== 16'h0000) begin errors++; $display("FAIL fault_rdata got %h want 0000", o_rdata); end
        do_access(0, 0, 0, 22'h000020, 16'h0);
        model_access(0, 0, 0, 22'h000020, 16'h0);
        checks++; if (o_lat != 0) begin errors++; $display("FAIL fault_keep_tag2 got lat %0d want 0", o_lat); end
        do_access(0, 0, 0, 22'h000030, 16'h0);
        model_access(0, 0, 0, 22'h000030, 16'h0);
        checks++; if (o_lat != 0) begin errors++; $display("FAIL fault_keep_tag3 got lat %0d want 0", o_lat); end
        do_access(0, 0, 0, 22'h000054, 16'h0);
        model_access(0, 0, 0, 22'h000054, 16'h0);
        checks++; if (o_lat != 9 || o_fill_addr !== 20'h00015) begin errors++; $display("FAIL fault_no_alloc got lat %0d maddr %h want 9 00015", o_lat, o_fill_addr); end
    endtask

    task automatic test_reset_mid_fill();
        int          n;
        int          beat;
        logic [31:0] tmp;
        n = 0; beat = 0;
        @(negedge clk);
        req = 1; write = 0; is_byte = 0; fault = 0; paddr = 22'h000064;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (mreq && !mwrite) begin
                tmp = mem[int'(maddr)];
                mrdata  = tmp[beat*4 +: 4];
                mstrobe = 1;
                n++; beat++;
            end
            @(posedge clk);
            @(negedge clk);
            mstrobe = 0;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL midfill_beats got %0d want 4", n); end
        reset_n = 0;
        #1;
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL midfill_mreq got %b want 0", mreq); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midfill_ready got %b want 0", ready); end
        req = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset();
        do_access(0, 0, 0, 22'h000064, 16'h0);
        model_access(0, 0, 0, 22'h000064, 16'h0);
        checks++; if (o_lat != 9 || o_fill_n != 8) begin errefill_report(); end
        checks++; if (o_fill_addr !== 20'h00019) begin errors++; $display("FAIL refill_maddr got %h want 00019", o_fill_addr); end
        checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL refill_rdata got %h want %h", o_rdata, e_rdata); end
    endtask

    task automatic errefill_report();
        errors++;
        $display("FAIL refill_len got lat %0d beats %0d want 9 8", o_lat, o_fill_n);
    endtask

    task automatic test_random();
        bit          w;
        bit          b;
        bit          f;
        logic [PA-1:0] a;
        logic [15:0] d;
        use_stall = 1;
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 15) == 0);
            a = {18'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d = 16'($urandom);
            do_access(w, b, f, a, d);
            model_access(w, b, f, a, d);
            checks++;
            if (o_timeout) begin
                errors++;
                $display("FAIL rnd_timeout #%0d addr %h", i, a);
                break;
            end
            checks++; if ((o_lat == 0) != e_hit) begin errors++; $display("FAIL rnd_hit #%0d addr %h got lat %0d want hit %0d", i, a, o_lat, e_hit); end
            if (!w) begin
                checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata #%0d addr %h got %h want %h", i, a, o_rdata, e_rdata); end
            end
            checks++; if (o_wb_n != (e_wb ? BEATS : 0)) begin errors++; $display("FAIL rnd_wb_beats #%0d got %0d want %0d", i, o_wb_n, e_wb ? BEATS : 0); end
            if (e_wb) begin
                checks++; if (o_wb_addr !== e_wb_addr || o_wb_line !== e_wb_line) begin errors++; $display("FAIL rnd_wb #%0d got %h:%h want %h:%h", i, o_wb_addr, o_wb_line, e_wb_addr, e_wb_line); end
            end
            checks++; if (o_fill_n != (e_hit ? 0 : BEATS)) begin errors++; $display("FAIL rnd_fill_beats #%0d got %0d want %0d", i, o_fill_n, e_hit ? 0 : BEATS); end
            if (!e_hit) begin
                checks++; if (o_fill_addr !== e_fill_addr) begin errors++; $display("FAIL rnd_fill_maddr #%0d got %h want %h", i, o_fill_addr, e_fill_addr); end
            end
        end
        use_stall = 0;
    endtask

    initial begin
        reset_n = 0; req = 0; write = 0; is_byte = 0; fault = 0;
        paddr = '0; wdata = '0; mrdata = '0; mstrobe = 0; use_stall = 0;
        init_mem();
        model_reset();
        test_reset();
        test_first_fill();
        test_hit_latency();
        test_byte_store();
        test_eviction();
        test_fault();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
